// File: rtl/ram_writer.sv
// rtl/ram_writer.sv - streams words into a RAM as bursts from base_addr, one write per accepted word
`timescale 1ns/1ps
module ram_writer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [15:0] MAX_LEN = 16'h8000;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pointer;
  logic [15:0]       remaining;
  logic              xfer;

  assign in_ready = (state == S_WRITE);
  assign busy     = (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pointer   <= '0;
      remaining <= '0;
      address   <= '0;
      data      <= '0;
      wren      <= 1'b0;
      error     <= 1'b0;
      count     <= '0;
    end else begin
      wren <= xfer;
      // address/data only move on a transfer so the RAM bus holds its last value otherwise
      if (xfer) begin
        address   <= pointer;
        data      <= in_data;
        pointer   <= pointer + 1'b1;
        remaining <= remaining - 16'd1;
        count     <= count + 16'd1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            if (length > MAX_LEN) begin
              error <= 1'b1;
            end else begin
              error     <= 1'b0;
              count     <= '0;
              pointer   <= base_addr;
              remaining <= length;
              state     <= (length == 16'd0) ? S_DONE : S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // abort wins over completion: an aborted burst never reports done
          if (abort) begin
            state <= S_IDLE;
          end else if (xfer && remaining == 16'd1) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_writer.md
RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 Parameter ADDR_W, default 15, RAM address width (32768 locations).
REQ-002 Parameter DATA_W, default 8, RAM word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load burst; sampled in IDLE only.
REQ-006 abort  input  1  terminates an active burst.
REQ-007 base_addr  input  ADDR_W  first RAM address of the burst; captured on accepted start.
REQ-008 length  input  16  word count, legal range 0..32768; captured on accepted start.
REQ-009 in_data  input  DATA_W  stream word.
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  block accepts a word this cycle; transfer = in_valid & in_ready.
REQ-012 address  output  ADDR_W  RAM write address, registered.
REQ-013 data  output  DATA_W  RAM write data, registered.
REQ-014 wren  output  1  RAM write enable, registered, one cycle per accepted word.
REQ-015 busy  output  1  high in WRITE state.
REQ-016 done  output  1  one-cycle pulse at burst completion.
REQ-017 error  output  1  sticky flag, set by illegal length; cleared by next accepted start or reset.
REQ-018 count  output  16  words written in current/last burst.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, DONE; encoding free.
REQ-020 IDLE: start=1 and length in 1..32768 -> WRITE at next edge; pointer<=base_addr, remaining<=length, count<=0, error<=0.
REQ-021 IDLE: start=1 and length=0 -> DONE at next edge, no writes, count<=0, error<=0.
REQ-022 IDLE: start=1 and length>32768 -> stay IDLE, error<=1, no writes, no done.
REQ-023 start while in WRITE or DONE SHALL be ignored.
REQ-024 in_ready SHALL be 1 exactly when state is WRITE; combinational from state only (no dependency on in_valid).
REQ-025 Transfer at edge E: during cycle after E wren=1, address=pointer value at E, data=in_data at E; pointer increments, remaining decrements, count increments at E.
REQ-026 No transfer at edge E: wren=0 next cycle; address/data hold previous values.
REQ-027 Pointer SHALL wrap modulo 2^ADDR_W (32767 -> 0) without flagging error.
REQ-028 Transfer with remaining=1 -> DONE at same edge; in_ready=0 from next cycle; final word is not dropped.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-030 Throughput: one word per cycle with in_valid held high; latency from accepted word to wren = 1 cycle.
REQ-031 abort=1 in WRITE -> IDLE at next edge, no done pulse; a transfer coincident with abort SHALL still be written (wren next cycle) and counted.
REQ-032 abort in IDLE or DONE SHALL be ignored.
REQ-033 in_valid in IDLE/DONE SHALL be ignored; no wren generated.

Reset
REQ-034 rst=0 SHALL immediately force: state IDLE, in_ready=0, wren=0, busy=0, done=0, error=0, count=0, address=0, data=0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst with no further writes; no done after release.
REQ-036 After rst returns high, block SHALL accept start on the first rising edge.

Verification
REQ-037 base_addr=0x0010, length=4, in_valid high, in_data 0xA1..0xA4 -> wren for 4 consecutive cycles at addresses 0x0010..0x0013 with 0xA1..0xA4, done pulse coincident with last wren, count=4.
REQ-038 base_addr=0x7FFE, length=3, data 0x11,0x22,0x33 -> writes to 0x7FFE, 0x7FFF, 0x0000; error=0.
REQ-039 length=0 -> no wren, done pulse 2nd cycle after start; length=40000 -> error=1, busy stays 0, no done.
REQ-040 length=5 with in_valid toggling every other cycle -> exactly 5 wren pulses, each 1 cycle after its accepted transfer; done after 5th.
REQ-041 length=8, abort after 3 transfers with a 4th transfer on the abort edge -> 4 writes, count=4, no done, in_ready=0 next cycle.
REQ-042 rst pulled low for 5 ps mid-burst (asynchronous to clk) -> all outputs zero immediately, no wren after release, new start accepted on first edge.
